// File: rtl/palette_lut_banked_if.sv
// Pixel, palette-write and frame-control signals of the banked palette LUT.
// The renderer holds the master side and the LUT holds the slave side.
interface palette_lut_banked_if #(
  parameter int INDEX_W = 4,
  parameter int CHAN_W  = 4,
  parameter int BANK_W  = 1
);
  logic                  frame_start;
  logic                  wr_en;
  logic [BANK_W-1:0]     wr_bank;
  logic [INDEX_W-1:0]    wr_index;
  logic [3*CHAN_W-1:0]   wr_rgb;
  logic [BANK_W-1:0]     bank_sel;
  logic                  hl_en;
  logic [INDEX_W-1:0]    hl_index;
  logic                  pix_valid;
  logic [INDEX_W-1:0]    pix_index;
  logic [CHAN_W-1:0]     red;
  logic [CHAN_W-1:0]     green;
  logic [CHAN_W-1:0]     blue;
  logic                  rgb_valid;
  logic [BANK_W-1:0]     active_bank;

  modport master (
    output frame_start, wr_en, wr_bank, wr_index, wr_rgb, bank_sel,
           hl_en, hl_index, pix_valid, pix_index,
    input  red, green, blue, rgb_valid, active_bank
  );

  modport slave (
    input  frame_start, wr_en, wr_bank, wr_index, wr_rgb, bank_sel,
           hl_en, hl_index, pix_valid, pix_index,
    output red, green, blue, rgb_valid, active_bank
  );
endinterface

// File: rtl/palette_lut_banked.sv
// Runtime-loadable multi-bank colour LUT with a 2-stage lookup pipeline,
// frame-synchronous bank switching and a frame-counted blink highlight.
module palette_lut_banked #(
  parameter int INDEX_W      = 4,
  parameter int CHAN_W       = 4,
  parameter int NUM_BANKS    = 2,
  parameter int BANK_W       = 1,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                 Clk,
  input  logic                 Reset,
  palette_lut_banked_if.slave  bus
);

  localparam int ENTRIES    = 1 << INDEX_W;
  localparam int BANK_SLOTS = 1 << BANK_W;
  localparam int RGB_W      = 3 * CHAN_W;
  localparam int CNT_W      = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  function automatic logic bank_ok(input logic [BANK_W-1:0] b);
    return 32'(b) < NUM_BANKS;
  endfunction

  function automatic logic [RGB_W-1:0] highlight(input logic [RGB_W-1:0] c,
                                                 input logic            en);
    return en ? ~c : c;
  endfunction

  logic [BANK_SLOTS-1:0][RGB_W-1:0] rd_ent;

  // Bank slots beyond NUM_BANKS have no storage and read as zero; they are never selected.
  for (genvar b = 0; b < BANK_SLOTS; b++) begin : g_bank
    if (b < NUM_BANKS) begin : g_mem
      logic [RGB_W-1:0] mem_q [ENTRIES];

      always_ff @(posedge Clk) begin
        if (Reset) begin
          for (int i = 0; i < ENTRIES; i++) mem_q[i] <= '0;
        end else if (bus.wr_en && bus.wr_bank == BANK_W'(b)) begin
          mem_q[bus.wr_index] <= bus.wr_rgb;
        end
      end

      assign rd_ent[b] = mem_q[bus.pix_index];
    end else begin : g_none
      assign rd_ent[b] = '0;
    end
  end

  logic [BANK_W-1:0] bank_q, bank_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              phase_q, phase_d;

  always_comb begin
    bank_d  = bank_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (bus.frame_start) begin
      if (bank_ok(bus.bank_sel)) bank_d = bus.bank_sel;
      if (32'(cnt_q) == BLINK_FRAMES - 1) begin
        cnt_d   = '0;
        phase_d = ~phase_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      bank_q  <= '0;
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      bank_q  <= bank_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  // Stage 1: read-first lookup in the current bank; the blink phase travels with the pixel
  logic               vld_p1_q;
  logic [RGB_W-1:0]   ent_p1_q;
  logic [INDEX_W-1:0] idx_p1_q;
  logic               phase_p1_q;

  always_ff @(posedge Clk) begin
    if (Reset) vld_p1_q <= 1'b0;
    else       vld_p1_q <= bus.pix_valid;
    ent_p1_q   <= rd_ent[bank_q];
    idx_p1_q   <= bus.pix_index;
    phase_p1_q <= phase_q;
  end

  // Stage 2: highlight and output registers; colour holds when no pixel arrives
  logic               vld_p2_q;
  logic [RGB_W-1:0]   rgb_p2_q;
  logic               hl_hit;

  assign hl_hit = bus.hl_en && phase_p1_q && (idx_p1_q == bus.hl_index);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      vld_p2_q <= 1'b0;
      rgb_p2_q <= '0;
    end else begin
      vld_p2_q <= vld_p1_q;
      if (vld_p1_q) rgb_p2_q <= highlight(ent_p1_q, hl_hit);
    end
  end

  assign bus.red         = rgb_p2_q[3*CHAN_W-1 -: CHAN_W];
  assign bus.green       = rgb_p2_q[2*CHAN_W-1 -: CHAN_W];
  assign bus.blue        = rgb_p2_q[CHAN_W-1   -: CHAN_W];
  assign bus.rgb_valid   = vld_p2_q;
  assign bus.active_bank = bank_q;

endmodule

// File: tb/tb_palette_lut_banked.sv
// Bench for palette_lut_banked: directed vector table, blink and reset
// sequences, then random traffic against a behavioural palette model.
module tb_palette_lut_banked;

  localparam int IW = 4;
  localparam int CW = 4;
  localparam int NB = 2;
  localparam int BW = 2;
  localparam int BF = 2;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  palette_lut_banked_if #(.INDEX_W(IW), .CHAN_W(CW), .BANK_W(BW)) bus ();

  palette_lut_banked #(
    .INDEX_W(IW), .CHAN_W(CW), .NUM_BANKS(NB), .BANK_W(BW), .BLINK_FRAMES(BF)
  ) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [11:0] out_rgb();
    return {bus.red, bus.green, bus.blue};
  endfunction

  // Behavioural model: palette contents, display state and a 2-deep pixel delay line.
  typedef struct {
    bit          v;
    logic [11:0] rgb;
    int          idx;
    bit          ph;
  } pend_t;

  logic [11:0] m_pal [4][16];
  int          m_bank;
  int          m_frames;
  bit          m_phase;
  pend_t       m_pipe[$];
  logic [11:0] m_out;
  bit          m_vld;

  task automatic model_step();
    pend_t p;
    if (Reset) begin
      foreach (m_pal[b, i]) m_pal[b][i] = '0;
      m_bank = 0; m_frames = 0; m_phase = 0; m_out = '0; m_vld = 0;
      m_pipe.delete();
      return;
    end
    m_vld = 0;
    if (m_pipe.size() > 0) begin
      p = m_pipe.pop_front();
      m_vld = p.v;
      if (p.v)
        m_out = (bus.hl_en && p.ph && p.idx == int'(bus.hl_index)) ? 12'hFFF - p.rgb : p.rgb;
    end
    m_pipe.push_back('{bus.pix_valid, m_pal[m_bank][bus.pix_index], int'(bus.pix_index), m_phase});
    if (bus.wr_en && int'(bus.wr_bank) < NB) m_pal[bus.wr_bank][bus.wr_index] = bus.wr_rgb;
    if (bus.frame_start) begin
      if (int'(bus.bank_sel) < NB) m_bank = int'(bus.bank_sel);
      m_frames++;
      if (m_frames == BF) begin m_frames = 0; m_phase = ~m_phase; end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge Clk);
    #1;
    check("model_valid", bus.rgb_valid, m_vld);
    check("model_rgb", out_rgb(), m_out);
    check("model_bank", bus.active_bank, m_bank);
  endtask

  task automatic drive(input bit rst, input bit fs, input bit we, input logic [1:0] wb,
                       input logic [3:0] wi, input logic [11:0] wd, input logic [1:0] bs,
                       input bit pv, input logic [3:0] pi);
    Reset = rst; bus.frame_start = fs; bus.wr_en = we; bus.wr_bank = wb;
    bus.wr_index = wi; bus.wr_rgb = wd; bus.bank_sel = bs;
    bus.pix_valid = pv; bus.pix_index = pi;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic px(input string name, input logic [3:0] idx, input logic [11:0] exp);
    drive(0, 0, 0, 0, 0, 0, 0, 1, idx);
    tick();
    idle();
    tick();
    check({name, "_valid"}, bus.rgb_valid, 1);
    check({name, "_rgb"}, out_rgb(), exp);
  endtask

  task automatic frame(input logic [1:0] bs);
    drive(0, 1, 0, 0, 0, 0, bs, 0, 0);
    tick();
    idle();
  endtask

  typedef struct {
    bit rst, fs, we;
    logic [1:0]  wb;
    logic [3:0]  wi;
    logic [11:0] wd;
    logic [1:0]  bs;
    bit          pv;
    logic [3:0]  pi;
    bit          ev;
    logic [11:0] ergb;
    logic [1:0]  eb;
  } vec_t;

  vec_t tbl[19];

  initial begin
    bus.hl_en = 0; bus.hl_index = 0;
    idle();
    Reset = 1;

    //          rst fs we wb wi wd       bs pv pi  ev ergb     eb
    tbl[0]  = '{1, 0, 0, 0, 0, 12'h000, 0, 0, 0,  0, 12'h000, 0};
    tbl[1]  = '{0, 0, 0, 0, 0, 12'h000, 0, 1, 5,  0, 12'h000, 0};
    tbl[2]  = '{0, 0, 0, 0, 0, 12'h000, 0, 0, 0,  1, 12'h000, 0};
    tbl[3]  = '{0, 0, 1, 0, 3, 12'hA12, 0, 0, 0,  0, 12'h000, 0};
    tbl[4]  = '{0, 0, 0, 0, 0, 12'h000, 0, 1, 3,  0, 12'h000, 0};
    tbl[5]  = '{0, 0, 0, 0, 0, 12'h000, 0, 0, 0,  1, 12'hA12, 0};
    tbl[6]  = '{0, 0, 1, 0, 3, 12'hEED, 0, 1, 3,  0, 12'hA12, 0};
    tbl[7]  = '{0, 0, 0, 0, 0, 12'h000, 0, 1, 3,  1, 12'hA12, 0};
    tbl[8]  = '{0, 0, 0, 0, 0, 12'h000, 0, 0, 0,  1, 12'hEED, 0};
    tbl[9]  = '{0, 0, 1, 1, 3, 12'h367, 1, 0, 0,  0, 12'hEED, 0};
    tbl[10] = '{0, 0, 0, 0, 0, 12'h000, 1, 1, 3,  0, 12'hEED, 0};
    tbl[11] = '{0, 1, 0, 0, 0, 12'h000, 1, 0, 0,  1, 12'hEED, 1};
    tbl[12] = '{0, 0, 0, 0, 0, 12'h000, 0, 1, 3,  0, 12'hEED, 1};
    tbl[13] = '{0, 0, 0, 0, 0, 12'h000, 0, 0, 0,  1, 12'h367, 1};
    tbl[14] = '{0, 1, 0, 0, 0, 12'h000, 2, 0, 0,  0, 12'h367, 1};
    tbl[15] = '{0, 0, 0, 0, 0, 12'h000, 0, 0, 0,  0, 12'h367, 1};
    tbl[16] = '{0, 0, 1, 2, 3, 12'hFFF, 0, 0, 0,  0, 12'h367, 1};
    tbl[17] = '{0, 0, 0, 0, 0, 12'h000, 0, 1, 3,  0, 12'h367, 1};
    tbl[18] = '{0, 0, 0, 0, 0, 12'h000, 0, 0, 0,  1, 12'h367, 1};

    foreach (tbl[k]) begin
      drive(tbl[k].rst, tbl[k].fs, tbl[k].we, tbl[k].wb, tbl[k].wi, tbl[k].wd,
            tbl[k].bs, tbl[k].pv, tbl[k].pi);
      tick();
      check($sformatf("tbl%0d_valid", k), bus.rgb_valid, tbl[k].ev);
      check($sformatf("tbl%0d_rgb", k), out_rgb(), tbl[k].ergb);
      check($sformatf("tbl%0d_bank", k), bus.active_bank, tbl[k].eb);
    end

    // Blink: half-period of 2 frames on index 3; index 4 stays untouched
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 1, 0, 3, 12'hA12, 0, 0, 0); tick();
    drive(0, 0, 1, 0, 4, 12'h4B7, 0, 0, 0); tick();
    idle();
    bus.hl_en = 1; bus.hl_index = 3;
    px("blink_f0", 3, 12'hA12);
    frame(0);
    px("blink_f1", 3, 12'hA12);
    frame(0);
    px("blink_on", 3, 12'h5ED);
    px("blink_other", 4, 12'h4B7);
    frame(0);
    px("blink_on2", 3, 12'h5ED);
    frame(0);
    px("blink_off", 3, 12'hA12);
    bus.hl_en = 0;

    // Reset with two pixels in flight
    drive(0, 0, 0, 0, 0, 0, 0, 1, 3); tick();
    drive(1, 0, 0, 0, 0, 0, 0, 1, 4); tick();
    check("rst_flight0_valid", bus.rgb_valid, 0);
    check("rst_flight0_rgb", out_rgb(), 12'h000);
    idle(); tick();
    check("rst_flight1_valid", bus.rgb_valid, 0);
    for (int b = 0; b < NB; b++) begin
      if (b > 0) frame(2'(b));
      for (int i = 0; i < 16; i++) px($sformatf("clear_b%0d_i%0d", b, i), 4'(i), 12'h000);
    end

    // Random traffic
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0); tick();
    for (int c = 0; c < 600; c++) begin
      drive($urandom_range(0, 99) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0,
            2'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 12'($urandom),
            2'($urandom_range(0, 3)), $urandom_range(0, 3) != 0, 4'($urandom_range(0, 3)));
      bus.hl_en = $urandom_range(0, 1) == 1;
      bus.hl_index = 4'($urandom_range(0, 3));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
